// File: rtl/fp_pkg.sv
// Shared float32 definitions for the int-to-float encoder and the adder path.
package fp_pkg;

  localparam int FP32_EXP_BIAS = 127;
  localparam int FP32_EXP_W    = 8;
  localparam int FP32_MAN_W    = 23;

  // Field slices of a packed float32 word.
  localparam int FP32_SIGN_BIT = 31;
  localparam int FP32_EXP_HI   = 30;
  localparam int FP32_EXP_LO   = 23;
  localparam int FP32_MAN_HI   = 22;
  localparam int FP32_MAN_LO   = 0;

  // Exponent of a 32-bit magnitude whose MSB sits at bit 31, before any shift.
  localparam logic [FP32_EXP_W-1:0] FP32_EXP_INT32 = FP32_EXP_W'(FP32_EXP_BIAS + 31);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } fp_state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 23-bit mantissa with guard and sticky bits.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [FP32_MAN_W-1:0] man,
  input  logic                  g,
  input  logic                  s,
  input  logic [FP32_EXP_W-1:0] exp,
  output logic [FP32_MAN_W-1:0] man_rnd,
  output logic [FP32_EXP_W-1:0] exp_rnd
);

  logic            inc;
  logic [FP32_MAN_W:0] sum;

  // Increment above half, or at exactly half when the mantissa is odd;
  // the adder carry means the mantissa wrapped to zero and the exponent grows.
  always_comb begin
    inc     = g & (s | man[0]);
    sum     = {1'b0, man} + {{FP32_MAN_W{1'b0}}, inc};
    man_rnd = sum[FP32_MAN_W-1:0];
    exp_rnd = exp + {{(FP32_EXP_W-1){1'b0}}, sum[FP32_MAN_W]};
  end

endmodule

// File: rtl/int_to_float_seq.sv
// Iterative 32-bit integer to float32 converter, one normalisation shift per clock.
module int_to_float_seq
  import fp_pkg::*;
#(
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  fp_state_t             state;
  logic                  sign;
  logic [31:0]           mag;
  logic [FP32_EXP_W-1:0] exp;
  logic [31:0]           out_q;

  logic                  in_neg;
  logic [31:0]           in_mag;
  logic [FP32_MAN_W-1:0] man_rnd;
  logic [FP32_EXP_W-1:0] exp_rnd;

  // Absolute value of the incoming operand; -2^31 maps onto 0x80000000.
  always_comb begin
    in_neg = SIGNED_IN & in_data[31];
    in_mag = in_neg ? (~in_data + 32'd1) : in_data;
  end

  fp_round_rne u_round (
    .man     (mag[30:8]),
    .g       (mag[7]),
    .s       (|mag[6:0]),
    .exp     (exp),
    .man_rnd (man_rnd),
    .exp_rnd (exp_rnd)
  );

  // Operation FSM with the magnitude/exponent shift registers and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sign  <= 1'b0;
      mag   <= '0;
      exp   <= '0;
      out_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sign <= in_neg;
            mag  <= in_mag;
            exp  <= FP32_EXP_INT32;
            if (in_mag == 32'd0) begin
              out_q <= '0;
              state <= ST_DONE;
            end else begin
              state <= ST_NORM;
            end
          end
        end
        ST_NORM: begin
          if (mag[31]) begin
            state <= ST_ROUND;
          end else begin
            mag <= {mag[30:0], 1'b0};
            exp <= exp - 8'd1;
          end
        end
        ST_ROUND: begin
          out_q <= {sign, exp_rnd, man_rnd};
          state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs; in_ready is masked while reset is held.
  always_comb begin
    in_ready  = (state == ST_IDLE) && !rst;
    out_valid = (state == ST_DONE);
    out_data  = out_q;
  end

endmodule
